i2s_shift_engine: RTL and testbench

Serial-side end of the audio FIFO path: pops 64-bit stereo frames from the show-ahead playback FIFO and serialises them onto I2S DACDAT. In parallel it deserialises ADCDAT into 64-bit frames and pushes them into the capture FIFO. It is the I2S bus master, generating BCLK and LRCLK, and runs entirely in the audio clock domain that clocks the read side of the playback FIFO and the write side of the capture FIFO.

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_shift_engine_if.sv | 18 +
 rtl/i2s_shift_engine_bclk_gen.sv | 45 ++++
 rtl/i2s_shift_engine.sv | 129 ++++++++++++
 tb/tb_i2s_shift_engine.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S shift engine.
package i2s_pkg;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int BITCNT_W   = 6;
  localparam logic [BITCNT_W-1:0] LOAD_BIT = BITCNT_W'(1);

  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } frame_t;

  // SYNC: running but no frame start seen yet, so no capture is complete.
  typedef enum logic {ST_SYNC, ST_FRAME} eng_state_e;

  function automatic logic is_right_slot(input logic [BITCNT_W-1:0] b);
    return b[BITCNT_W-1];
  endfunction
endpackage

// File: rtl/i2s_shift_engine_if.sv
// FIFO-side bus between the shift engine (master) and the playback/capture FIFOs.
interface i2s_shift_engine_if;
  logic [63:0] playback_fifo_data;
  logic        playback_fifo_empty;
  logic        playback_fifo_read;
  logic [63:0] capture_fifo_data;
  logic        capture_fifo_write;
  logic        capture_fifo_full;

  modport master (
    input  playback_fifo_data, playback_fifo_empty, capture_fifo_full,
    output playback_fifo_read, capture_fifo_data, capture_fifo_write
  );
  modport slave (
    output playback_fifo_data, playback_fifo_empty, capture_fifo_full,
    input  playback_fifo_read, capture_fifo_data, capture_fifo_write
  );
endinterface

// File: rtl/i2s_shift_engine_bclk_gen.sv
// BCLK divider: toggles the bit clock every BCLK_DIV clks and flags each edge
// one clk ahead so the engine's registers change together with BCLK.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic bclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);
  localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          tc;

  assign tc         = enable && (cnt_q == CW'(BCLK_DIV-1));
  assign rise_stb_o = tc && !bclk_q;
  assign fall_stb_o = tc &&  bclk_q;
  assign bclk_o     = bclk_q;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    bclk_d = bclk_q;
    if (!enable) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end
endmodule

// File: rtl/i2s_shift_engine.sv
// I2S master: serialises playback frames onto DACDAT and assembles ADCDAT into
// capture frames, with sticky underrun/overrun flags.
module i2s_shift_engine
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear_flags,
  i2s_shift_engine_if.master fifo,
  output logic i2s_bclk,
  output logic i2s_lrclk,
  output logic i2s_dacdat,
  input  logic i2s_adcdat,
  output logic underrun,
  output logic overrun
);
  logic rise_stb, fall_stb;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .bclk_o    (i2s_bclk),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb)
  );

  eng_state_e            st_q, st_d;
  logic [BITCNT_W-1:0]   b_q, b_d;
  logic                  lr_q, lr_d, dac_q, dac_d;
  logic [FRAME_BITS-1:0] pb_q, pb_d, cap_sh_q, cap_sh_d;
  frame_t                cap_q, cap_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic                  und_q, und_d, ovr_q, ovr_d;
  logic                  und_set, ovr_set;

  always_comb begin
    st_d     = st_q;
    b_d      = b_q;
    lr_d     = lr_q;
    dac_d    = dac_q;
    pb_d     = pb_q;
    cap_sh_d = cap_sh_q;
    cap_d    = cap_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    und_set  = 1'b0;
    ovr_set  = 1'b0;
    if (!enable) begin
      st_d     = ST_SYNC;
      b_d      = '1;
      lr_d     = 1'b1;
      dac_d    = 1'b0;
      pb_d     = '0;
      cap_sh_d = '0;
      cap_d    = '0;
    end else begin
      if (rise_stb) begin
        cap_sh_d = {cap_sh_q[FRAME_BITS-2:0], i2s_adcdat};
        // Sample during b=0 closes a frame only once a b=1 start has been seen.
        if (b_q == '0 && st_q == ST_FRAME) begin
          cap_d = frame_t'(cap_sh_d);
          if (fifo.capture_fifo_full) ovr_set = 1'b1;
          else                        wr_d    = 1'b1;
        end
      end
      if (fall_stb) begin
        b_d  = b_q + BITCNT_W'(1);
        lr_d = is_right_slot(b_d);
        if (b_d == LOAD_BIT) begin
          st_d = ST_FRAME;
          if (!fifo.playback_fifo_empty) begin
            pb_d  = fifo.playback_fifo_data;
            dac_d = fifo.playback_fifo_data[FRAME_BITS-1];
            rd_d  = 1'b1;
          end else begin
            pb_d    = '0;
            dac_d   = 1'b0;
            und_set = 1'b1;
          end
        end else begin
          dac_d = pb_q[FRAME_BITS-2];
          pb_d  = pb_q << 1;
        end
      end
    end
    und_d = und_set | (und_q & ~clear_flags);
    ovr_d = ovr_set | (ovr_q & ~clear_flags);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q     <= ST_SYNC;
      b_q      <= '1;
      lr_q     <= 1'b1;
      dac_q    <= 1'b0;
      pb_q     <= '0;
      cap_sh_q <= '0;
      cap_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      und_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      b_q      <= b_d;
      lr_q     <= lr_d;
      dac_q    <= dac_d;
      pb_q     <= pb_d;
      cap_sh_q <= cap_sh_d;
      cap_q    <= cap_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      und_q    <= und_d;
      ovr_q    <= ovr_d;
    end
  end

  assign i2s_lrclk               = lr_q;
  assign i2s_dacdat              = dac_q;
  assign fifo.playback_fifo_read = rd_q;
  assign fifo.capture_fifo_data  = cap_q;
  assign fifo.capture_fifo_write = wr_q;
  assign underrun                = und_q;
  assign overrun                 = ovr_q;
endmodule

// File: tb/tb_i2s_shift_engine.sv
// Directed bench for i2s_shift_engine at BCLK_DIV=4: start-up timing, DACDAT
// serialisation, loopback capture, flags and mid-frame abort.
module tb_i2s_shift_engine;
  logic clk = 1'b0;
  logic reset_n, enable, clear_flags;
  logic i2s_bclk, i2s_lrclk, i2s_dacdat, i2s_adcdat;
  logic underrun, overrun;
  logic loop_en;

  i2s_shift_engine_if fifo ();

  i2s_shift_engine #(.BCLK_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear_flags(clear_flags),
    .fifo       (fifo.master),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_dacdat (i2s_dacdat),
    .i2s_adcdat (i2s_adcdat),
    .underrun   (underrun),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  assign i2s_adcdat = loop_en ? i2s_dacdat : 1'b0;

  // Show-ahead playback FIFO model: words[] filled by the stimulus, rd_ptr by pops.
  logic [63:0] words [0:15];
  int n_words = 0;
  int rd_ptr  = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  assign fifo.playback_fifo_empty = (rd_ptr >= n_words);
  assign fifo.playback_fifo_data  = (rd_ptr < n_words) ? words[rd_ptr[3:0]] : 64'h0;

  always @(posedge clk) begin
    if (fifo.playback_fifo_read) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_ptr < n_words) rd_ptr <= rd_ptr + 1;
    end
    if (fifo.capture_fifo_write) wr_cnt <= wr_cnt + 1;
  end

  int nchk = 0;
  int npass = 0;
  int e = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1; e++;
  endtask

  task automatic adv(input int n);
    while (e < n) step();
  endtask

  task automatic go();
    enable = 1'b0; step(); step();
    enable = 1'b1; e = 0;
  endtask

  task automatic push(input logic [63:0] w);
    words[n_words[3:0]] = w;
    n_words = n_words + 1;
  endtask

  logic [63:0] got;
  int rd0, wr0;

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear_flags = 1'b0; loop_en = 1'b0;
    fifo.capture_fifo_full = 1'b0;
    step(); step();
    chk("rst_bclk", {63'd0, i2s_bclk}, 64'd0);
    chk("rst_lrclk", {63'd0, i2s_lrclk}, 64'd1);
    chk("rst_flags", {62'd0, underrun, overrun}, 64'd0);
    reset_n = 1'b1;

    // Idle with enable low
    repeat (100) step();
    chk("idle_pins", {61'd0, i2s_bclk, i2s_lrclk, i2s_dacdat}, 64'b010);
    chk("idle_strobes", 64'(rd_cnt + wr_cnt), 64'd0);
    chk("idle_capdata", fifo.capture_fifo_data, 64'd0);

    // Start-up timing and DACDAT serialisation
    push(64'hA5A5_0001_8000_00FF);
    go();
    adv(3);  chk("su_bclk_e3", {63'd0, i2s_bclk}, 64'd0);
    adv(4);  chk("su_bclk_e4", {63'd0, i2s_bclk}, 64'd1);
    adv(7);  chk("su_lr_e7", {63'd0, i2s_lrclk}, 64'd1);
    adv(8);  chk("su_lr_e8", {63'd0, i2s_lrclk}, 64'd0);
    adv(15); chk("su_rd_e15", {63'd0, fifo.playback_fifo_read}, 64'd0);
    adv(16); chk("su_rd_e16", {63'd0, fifo.playback_fifo_read}, 64'd1);
    got = '0;
    got[63] = i2s_dacdat;
    adv(17); chk("su_rd_e17", {63'd0, fifo.playback_fifo_read}, 64'd0);
    for (int k = 2; k < 64; k++) begin
      adv(8 + 8*k);
      got[64-k] = i2s_dacdat;
      if (k == 31) chk("lr_b31", {63'd0, i2s_lrclk}, 64'd0);
      if (k == 32) chk("lr_b32", {63'd0, i2s_lrclk}, 64'd1);
    end
    adv(520); got[0] = i2s_dacdat;
    chk("dac_word", got, 64'hA5A5_0001_8000_00FF);
    chk("rd_once", 64'(rd_cnt), 64'd1);

    // Loopback capture, two frames
    loop_en = 1'b1;
    push(64'h1234_5678_9ABC_DEF0);
    push(64'hFFFF_0000_0F0F_F0F0);
    go();
    wr0 = wr_cnt;
    adv(523);  chk("lb0_wr_pre", {63'd0, fifo.capture_fifo_write}, 64'd0);
    adv(524);  chk("lb0_wr", {63'd0, fifo.capture_fifo_write}, 64'd1);
               chk("lb0_data", fifo.capture_fifo_data, 64'h1234_5678_9ABC_DEF0);
    adv(525);  chk("lb0_wr_post", {63'd0, fifo.capture_fifo_write}, 64'd0);
               chk("lb0_hold", fifo.capture_fifo_data, 64'h1234_5678_9ABC_DEF0);
    adv(1035); chk("lb1_wr_pre", {63'd0, fifo.capture_fifo_write}, 64'd0);
    adv(1036); chk("lb1_wr", {63'd0, fifo.capture_fifo_write}, 64'd1);
               chk("lb1_data", fifo.capture_fifo_data, 64'hFFFF_0000_0F0F_F0F0);
    adv(1037); chk("lb_wr_count", 64'(wr_cnt - wr0), 64'd2);
    loop_en = 1'b0;

    // Underrun: playback FIFO empty at frame start
    rd0 = rd_cnt;
    go();
    adv(15); chk("ur_pre", {63'd0, underrun}, 64'd0);
    adv(16); chk("ur_set", {63'd0, underrun}, 64'd1);
    got = {63'd0, i2s_dacdat};
    for (int k = 2; k < 64; k++) begin
      adv(8 + 8*k);
      got = got | {63'd0, i2s_dacdat};
    end
    adv(520); got = got | {63'd0, i2s_dacdat};
    chk("ur_dac_zero", got, 64'd0);
    chk("ur_no_rd", 64'(rd_cnt - rd0), 64'd0);
    enable = 1'b0; step(); step(); step();
    chk("ur_retained_idle", {63'd0, underrun}, 64'd1);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("ur_cleared", {63'd0, underrun}, 64'd0);

    // Overrun: capture FIFO full at frame completion
    push(64'h0123_4567_89AB_CDEF);
    push(64'h0F0F_0F0F_0F0F_0F0F);
    fifo.capture_fifo_full = 1'b1;
    go();
    wr0 = wr_cnt;
    adv(523); chk("ov_pre", {63'd0, overrun}, 64'd0);
    adv(524); chk("ov_set", {63'd0, overrun}, 64'd1);
              chk("ov_no_wr", {63'd0, fifo.capture_fifo_write}, 64'd0);
    adv(1035); clear_flags = 1'b1;
    adv(1036); clear_flags = 1'b0;
    chk("ov_set_wins", {63'd0, overrun}, 64'd1);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("ov_cleared", {63'd0, overrun}, 64'd0);
    chk("ov_wr_count", 64'(wr_cnt - wr0), 64'd0);
    fifo.capture_fifo_full = 1'b0;

    // Abort mid-frame at b=40 and restart
    loop_en = 1'b1;
    push(64'hDEAD_BEEF_0000_FFFF);
    push(64'hCAFE_F00D_1357_2468);
    push(64'h0);
    go();
    wr0 = wr_cnt;
    adv(8 + 8*40);
    enable = 1'b0;
    repeat (10) step();
    chk("ab_idle_pins", {61'd0, i2s_bclk, i2s_lrclk, i2s_dacdat}, 64'b010);
    chk("ab_no_wr", 64'(wr_cnt - wr0), 64'd0);
    rd0 = rd_cnt;
    enable = 1'b1; e = 0;
    adv(3);  chk("ab_bclk_e3", {63'd0, i2s_bclk}, 64'd0);
    adv(4);  chk("ab_bclk_e4", {63'd0, i2s_bclk}, 64'd1);
    adv(8);  chk("ab_lr_e8", {63'd0, i2s_lrclk}, 64'd0);
    adv(15); chk("ab_rd_e15", {63'd0, fifo.playback_fifo_read}, 64'd0);
    adv(16); chk("ab_rd_e16", {63'd0, fifo.playback_fifo_read}, 64'd1);
    adv(523); chk("ab_no_wr_restart", 64'(wr_cnt - wr0), 64'd0);
    adv(524); chk("ab_wr", {63'd0, fifo.capture_fifo_write}, 64'd1);
              chk("ab_data", fifo.capture_fifo_data, 64'hCAFE_F00D_1357_2468);
    chk("ab_rd_count", 64'(rd_cnt - rd0), 64'd1);
    loop_en = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
